// File: rtl/wli_bank.sv
// Register bank with a command port: single-cycle load/clear/inc/set and
// bit-serial shift/rotate operations that take one edge per bit.
module wli_bank #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 4,
    localparam int unsigned DstW = $clog2(NREG),
    localparam int unsigned AmtW = $clog2(WIDTH) + 1
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [2:0]       CmdOp,
    input  logic [DstW-1:0]  CmdDst,
    input  logic [WIDTH-1:0] CmdData,
    input  logic [AmtW-1:0]  CmdAmt,
    input  logic [DstW-1:0]  RdSel,
    output logic [WIDTH-1:0] RdData,
    output logic             Busy,
    output logic             Done,
    output logic             Carry
);

    localparam logic [2:0] OpNop   = 3'b000;
    localparam logic [2:0] OpLoad  = 3'b001;
    localparam logic [2:0] OpClear = 3'b010;
    localparam logic [2:0] OpInc   = 3'b011;
    localparam logic [2:0] OpShl   = 3'b100;
    localparam logic [2:0] OpShr   = 3'b101;
    localparam logic [2:0] OpRol   = 3'b110;
    localparam logic [2:0] OpSet   = 3'b111;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  regs_q [NREG];
    logic [WIDTH-1:0]  regs_d [NREG];
    logic [AmtW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [DstW-1:0]   dst_q, dst_d;
    logic              carry_q, carry_d;
    logic              done_q, done_d;

    logic [DstW-1:0]   idx;
    logic              idx_ok;
    logic [WIDTH-1:0]  cur;
    logic [WIDTH:0]    stepped;
    logic [AmtW-1:0]   amt;

    // One bit-step of SHL/SHR/ROL; MSB of the result is the bit moved out.
    function automatic logic [WIDTH:0] step(input logic [2:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OpShl:   step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OpShr:   step = {v[0], 1'b0, v[WIDTH-1:1]};
            default: step = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
        endcase
    endfunction

    assign CmdReady = (state_q == StIdle) && ResetN;
    assign Busy     = (state_q == StShift);
    assign Done     = done_q;
    assign Carry    = carry_q;
    assign RdData   = (32'(RdSel) < NREG) ? regs_q[RdSel] : '0;

    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dst_d   = dst_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        amt     = CmdAmt;
        idx     = (state_q == StShift) ? dst_q : CmdDst;
        idx_ok  = 32'(idx) < NREG;
        cur     = idx_ok ? regs_q[idx] : '0;
        stepped = step(op_q, cur);

        if (state_q == StShift) begin
            if (idx_ok) regs_d[idx] = stepped[WIDTH-1:0];
            if (op_q != OpRol) carry_d = stepped[WIDTH];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == AmtW'(1)) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end else if (CmdValid && CmdReady) begin
            done_d = 1'b1;
            unique case (CmdOp)
                OpNop:   ;
                OpLoad:  if (idx_ok) regs_d[idx] = CmdData;
                OpClear: if (idx_ok) regs_d[idx] = '0;
                OpInc: begin
                    if (idx_ok) regs_d[idx] = cur + 1'b1;
                    carry_d = &cur;
                end
                OpSet:   if (idx_ok) regs_d[idx] = '1;
                OpShl, OpShr, OpRol: begin
                    // Shifts past the width are pointless; rotates keep the full count.
                    if (CmdOp != OpRol && CmdAmt > AmtW'(WIDTH)) amt = AmtW'(WIDTH);
                    if (amt != '0) begin
                        done_d  = 1'b0;
                        state_d = StShift;
                        cnt_d   = amt;
                        op_d    = CmdOp;
                        dst_d   = CmdDst;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q <= StIdle;
            regs_q  <= '{default: '0};
            cnt_q   <= '0;
            op_q    <= OpNop;
            dst_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_wli_bank.sv
// Directed bench for wli_bank: load/inc/shift/rotate, saturation, reset abort, back-to-back.
module tb_wli_bank;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        CmdValid;
    logic        CmdReady;
    logic [2:0]  CmdOp;
    logic [1:0]  CmdDst;
    logic [15:0] CmdData;
    logic [4:0]  CmdAmt;
    logic [1:0]  RdSel;
    logic [15:0] RdData;
    logic        Busy;
    logic        Done;
    logic        Carry;

    int checks = 0;
    int errors = 0;

    wli_bank #(.WIDTH(16), .NREG(4)) dut (
        .Clock(Clock), .ResetN(ResetN), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdDst(CmdDst), .CmdData(CmdData), .CmdAmt(CmdAmt),
        .RdSel(RdSel), .RdData(RdData), .Busy(Busy), .Done(Done), .Carry(Carry)
    );

    always #5 Clock = ~Clock;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [15:0] data,
                         input logic [4:0] amt);
        CmdValid = 1'b1;
        CmdOp    = op;
        CmdDst   = dst;
        CmdData  = data;
        CmdAmt   = amt;
        tick();
        CmdValid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input string tag, input logic [15:0] exp);
        RdSel = sel;
        #1;
        chk16(tag, RdData, exp);
    endtask

    initial begin
        int n;
        ResetN = 1'b0; CmdValid = 1'b0; CmdOp = 3'd0; CmdDst = 2'd0;
        CmdData = 16'h0; CmdAmt = 5'd0; RdSel = 2'd0;
        tick();
        tick();
        chk1("rst_ready", CmdReady, 1'b0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_done", Done, 1'b0);
        chk1("rst_carry", Carry, 1'b0);
        rd(2'd0, "rst_r0", 16'h0000);
        ResetN = 1'b1;
        #1;
        chk1("ready_after_rst", CmdReady, 1'b1);

        // LOAD R1 and single-cycle Done
        issue(3'b001, 2'd1, 16'h1234, 5'd0);
        chk1("load_done", Done, 1'b1);
        rd(2'd1, "load_r1", 16'h1234);
        tick();
        chk1("load_done_drop", Done, 1'b0);

        // INC wraps with carry, then clears carry
        issue(3'b001, 2'd2, 16'hFFFF, 5'd0);
        issue(3'b011, 2'd2, 16'h0, 5'd0);
        rd(2'd2, "inc_wrap", 16'h0000);
        chk1("inc_carry1", Carry, 1'b1);
        issue(3'b011, 2'd2, 16'h0, 5'd0);
        rd(2'd2, "inc_again", 16'h0001);
        chk1("inc_carry0", Carry, 1'b0);

        // SHL R0=0x8001 by 3; a LOAD R3 presented while busy must be ignored
        issue(3'b001, 2'd0, 16'h8001, 5'd0);
        issue(3'b100, 2'd0, 16'h0, 5'd3);
        CmdValid = 1'b1; CmdOp = 3'b001; CmdDst = 2'd3; CmdData = 16'hAAAA;
        chk1("shl_busy0", Busy, 1'b1);
        chk1("shl_ready0", CmdReady, 1'b0);
        chk1("shl_done0", Done, 1'b0);
        rd(2'd0, "shl_pre", 16'h8001);
        tick();
        rd(2'd0, "shl_step1", 16'h0002);
        chk1("shl_carry1", Carry, 1'b1);
        chk1("shl_busy1", Busy, 1'b1);
        chk1("shl_ready1", CmdReady, 1'b0);
        tick();
        CmdValid = 1'b0;
        rd(2'd0, "shl_step2", 16'h0004);
        chk1("shl_busy2", Busy, 1'b1);
        chk1("shl_done2", Done, 1'b0);
        tick();
        rd(2'd0, "shl_step3", 16'h0008);
        chk1("shl_busy3", Busy, 1'b0);
        chk1("shl_done3", Done, 1'b1);
        chk1("shl_carry_end", Carry, 1'b0);
        rd(2'd3, "ignored_load", 16'h0000);

        // ROL R3=0x8001 by 1, carry unchanged
        issue(3'b001, 2'd3, 16'h8001, 5'd0);
        issue(3'b110, 2'd3, 16'h0, 5'd1);
        chk1("rol_busy", Busy, 1'b1);
        tick();
        rd(2'd3, "rol_r3", 16'h0003);
        chk1("rol_done", Done, 1'b1);
        chk1("rol_carry", Carry, 1'b0);

        // Zero amount is a one-cycle no-op with Done
        issue(3'b100, 2'd3, 16'h0, 5'd0);
        chk1("amt0_busy", Busy, 1'b0);
        chk1("amt0_done", Done, 1'b1);
        rd(2'd3, "amt0_r3", 16'h0003);

        // SHR 0x0001 by 20 saturates to 16 steps
        issue(3'b001, 2'd3, 16'h0001, 5'd0);
        issue(3'b101, 2'd3, 16'h0, 5'd20);
        n = 0;
        while (!Done && n < 40) begin
            tick();
            n++;
        end
        checks++;
        assert (n == 16) else begin
            errors++;
            $error("FAIL shr_latency observed %0d expected %0d", n, 16);
        end
        rd(2'd3, "shr_r3", 16'h0000);
        chk1("shr_carry", Carry, 1'b0);

        // SHL R1 by 8, reset on the 4th shift edge aborts without Done
        issue(3'b001, 2'd1, 16'h00FF, 5'd0);
        issue(3'b100, 2'd1, 16'h0, 5'd8);
        tick();
        tick();
        tick();
        rd(2'd1, "abort_mid", 16'h07F8);
        ResetN = 1'b0;
        tick();
        chk1("abort_busy", Busy, 1'b0);
        chk1("abort_done", Done, 1'b0);
        for (int i = 0; i < 4; i++) rd(2'(i), "abort_regs", 16'h0000);
        ResetN = 1'b1;
        #1;
        chk1("abort_ready", CmdReady, 1'b1);
        tick();
        chk1("abort_no_done", Done, 1'b0);

        // Back-to-back LOAD R0, LOAD R1, SET R2
        CmdValid = 1'b1; CmdOp = 3'b001; CmdDst = 2'd0; CmdData = 16'h1111;
        tick();
        chk1("b2b_done1", Done, 1'b1);
        CmdDst = 2'd1; CmdData = 16'h2222;
        tick();
        chk1("b2b_done2", Done, 1'b1);
        CmdOp = 3'b111; CmdDst = 2'd2;
        tick();
        chk1("b2b_done3", Done, 1'b1);
        CmdValid = 1'b0;
        tick();
        chk1("b2b_done_drop", Done, 1'b0);
        rd(2'd0, "b2b_r0", 16'h1111);
        rd(2'd1, "b2b_r1", 16'h2222);
        rd(2'd2, "b2b_r2", 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
